// File: rtl/spi_slave_bus_sequencer.sv
// rtl/spi_slave_bus_sequencer.sv - SPI-side transfer sequencer driving a single-outstanding word bus
module spi_slave_bus_sequencer #(
    parameter int PREFETCH_DEPTH = 2
) (
    input  logic        sclk,
    input  logic        sys_rstn,
    input  logic [31:0] ctrl_addr,
    input  logic        ctrl_addr_valid,
    input  logic        ctrl_rd_wr,
    input  logic [31:0] ctrl_data_rx,
    input  logic        ctrl_data_rx_valid,
    output logic        ctrl_data_rx_ready,
    output logic [31:0] ctrl_data_tx,
    output logic        ctrl_data_tx_valid,
    input  logic        ctrl_data_tx_ready,
    input  logic [15:0] wrap_length,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_WAIT = 3'd1,
        WR_REQ  = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    state_t      state, state_d;
    state_t      pend, pend_d;
    logic        discard, discard_d;
    logic [31:0] base;
    logic [15:0] offset;
    logic [15:0] offset_inc;
    logic        offset_adv;
    logic [31:0] wdata;
    logic [31:0] mem [PREFETCH_DEPTH];
    logic [2:0]  count;
    logic [2:0]  push_idx;
    logic        push, pop;
    state_t      target;
    logic        inflight;

    assign offset_inc         = offset + 16'd1;
    assign bus_addr           = base + {14'b0, offset, 2'b00};
    assign bus_wdata          = wdata;
    assign bus_we             = (state == WR_REQ);
    assign bus_req            = (state == WR_REQ) ||
                                ((state == RD_REQ) && (count < 3'(PREFETCH_DEPTH)));
    assign ctrl_data_rx_ready = (state == WR_WAIT);
    assign ctrl_data_tx_valid = (count != 3'd0);
    assign ctrl_data_tx       = mem[0];

    assign pop      = ctrl_data_tx_valid && ctrl_data_tx_ready;
    assign push     = (state == RD_RESP) && bus_rvalid && !discard && !ctrl_addr_valid;
    assign push_idx = count - {2'b00, pop};
    assign target   = ctrl_rd_wr ? RD_REQ : WR_WAIT;
    // A read granted this cycle, or already waiting for its response, is still owed a response.
    assign inflight = ((state == RD_REQ) && bus_req && bus_gnt) ||
                      ((state == RD_RESP) && !bus_rvalid);

    always_comb begin
        state_d    = state;
        pend_d     = pend;
        discard_d  = discard;
        offset_adv = 1'b0;
        case (state)
            WR_WAIT: if (ctrl_data_rx_valid) state_d = WR_REQ;
            WR_REQ: begin
                if (bus_gnt) begin
                    offset_adv = 1'b1;
                    state_d    = WR_WAIT;
                end
            end
            RD_REQ: if (bus_req && bus_gnt) state_d = RD_RESP;
            RD_RESP: begin
                if (bus_rvalid) begin
                    if (discard) begin
                        discard_d = 1'b0;
                        state_d   = pend;
                    end else begin
                        offset_adv = 1'b1;
                        state_d    = RD_REQ;
                    end
                end
            end
            default: state_d = state;
        endcase
        if (ctrl_addr_valid) begin
            offset_adv = 1'b0;
            if (inflight) begin
                // Park in RD_RESP until the stale response drains, then start the new transfer.
                state_d   = RD_RESP;
                discard_d = 1'b1;
                pend_d    = target;
            end else begin
                state_d   = target;
                discard_d = 1'b0;
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (!sys_rstn) begin
            state   <= IDLE;
            pend    <= IDLE;
            discard <= 1'b0;
            base    <= 32'd0;
            offset  <= 16'd0;
            wdata   <= 32'd0;
        end else begin
            state   <= state_d;
            pend    <= pend_d;
            discard <= discard_d;
            if (ctrl_addr_valid) begin
                base   <= ctrl_addr & ~32'h3;
                offset <= 16'd0;
            end else if (offset_adv) begin
                offset <= ((wrap_length != 16'd0) && (offset_inc == wrap_length)) ? 16'd0 : offset_inc;
            end
            if ((state == WR_WAIT) && ctrl_data_rx_valid) wdata <= ctrl_data_rx;
        end
    end

    // Shift-register prefetch buffer: head always sits in mem[0].
    always_ff @(posedge sclk) begin
        if (!sys_rstn) begin
            count <= 3'd0;
            for (int i = 0; i < PREFETCH_DEPTH; i++) mem[i] <= 32'd0;
        end else if (ctrl_addr_valid) begin
            count <= 3'd0;
        end else begin
            if (pop) begin
                for (int i = 0; i < PREFETCH_DEPTH - 1; i++) mem[i] <= mem[i + 1];
            end
            if (push) begin
                for (int i = 0; i < PREFETCH_DEPTH; i++) begin
                    if (i == int'(push_idx)) mem[i] <= bus_rdata;
                end
            end
            count <= count + {2'b00, push} - {2'b00, pop};
        end
    end

endmodule

// File: tb/tb_spi_slave_bus_sequencer.sv
// tb/tb_spi_slave_bus_sequencer.sv - directed bench for spi_slave_bus_sequencer
module tb_spi_slave_bus_sequencer;

    logic        sclk = 1'b0;
    logic        sys_rstn;
    logic [31:0] ctrl_addr;
    logic        ctrl_addr_valid;
    logic        ctrl_rd_wr;
    logic [31:0] ctrl_data_rx;
    logic        ctrl_data_rx_valid;
    logic        ctrl_data_rx_ready;
    logic [31:0] ctrl_data_tx;
    logic        ctrl_data_tx_valid;
    logic        ctrl_data_tx_ready;
    logic [15:0] wrap_length;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    spi_slave_bus_sequencer #(.PREFETCH_DEPTH(2)) dut (
        .sclk               (sclk),
        .sys_rstn           (sys_rstn),
        .ctrl_addr          (ctrl_addr),
        .ctrl_addr_valid    (ctrl_addr_valid),
        .ctrl_rd_wr         (ctrl_rd_wr),
        .ctrl_data_rx       (ctrl_data_rx),
        .ctrl_data_rx_valid (ctrl_data_rx_valid),
        .ctrl_data_rx_ready (ctrl_data_rx_ready),
        .ctrl_data_tx       (ctrl_data_tx),
        .ctrl_data_tx_valid (ctrl_data_tx_valid),
        .ctrl_data_tx_ready (ctrl_data_tx_ready),
        .wrap_length        (wrap_length),
        .bus_req            (bus_req),
        .bus_we             (bus_we),
        .bus_addr           (bus_addr),
        .bus_wdata          (bus_wdata),
        .bus_gnt            (bus_gnt),
        .bus_rvalid         (bus_rvalid),
        .bus_rdata          (bus_rdata)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge sclk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " bus_req"},   32'(bus_req), 32'd0);
        check({tag, " bus_we"},    32'(bus_we), 32'd0);
        check({tag, " bus_addr"},  bus_addr, 32'd0);
        check({tag, " bus_wdata"}, bus_wdata, 32'd0);
        check({tag, " rx_ready"},  32'(ctrl_data_rx_ready), 32'd0);
        check({tag, " tx_valid"},  32'(ctrl_data_tx_valid), 32'd0);
        check({tag, " tx"},        ctrl_data_tx, 32'd0);
    endtask

    logic [31:0] wr_data [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};

    initial begin
        sys_rstn = 1'b0; ctrl_addr = 32'd0; ctrl_addr_valid = 1'b0; ctrl_rd_wr = 1'b0;
        ctrl_data_rx = 32'd0; ctrl_data_rx_valid = 1'b0; ctrl_data_tx_ready = 1'b0;
        wrap_length = 16'd0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        step(); step();
        check_reset_outputs("reset");

        // Write 3 words at 0x100 with immediate grant
        sys_rstn = 1'b1; ctrl_addr = 32'h100; ctrl_addr_valid = 1'b1; ctrl_rd_wr = 1'b0; bus_gnt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); ctrl_addr_valid = 1'b0;
            check("wr rx_ready", 32'(ctrl_data_rx_ready), 32'd1);
            ctrl_data_rx_valid = 1'b1; ctrl_data_rx = wr_data[k];
            step(); ctrl_data_rx_valid = 1'b0;
            check("wr req",   32'(bus_req), 32'd1);
            check("wr we",    32'(bus_we), 32'd1);
            check("wr addr",  bus_addr, 32'h100 + 32'(4 * k));
            check("wr wdata", bus_wdata, wr_data[k]);
        end

        // Stalled write grant: request held stable
        step(); bus_gnt = 1'b0; ctrl_data_rx_valid = 1'b1; ctrl_data_rx = 32'hA5A5_5A5A;
        step(); ctrl_data_rx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall req",      32'(bus_req), 32'd1);
            check("stall addr",     bus_addr, 32'h10C);
            check("stall wdata",    bus_wdata, 32'hA5A5_5A5A);
            check("stall rx_ready", 32'(ctrl_data_rx_ready), 32'd0);
            step();
        end
        bus_gnt = 1'b1;
        step();
        check("stall done rx_ready", 32'(ctrl_data_rx_ready), 32'd1);

        // Linear read crossing the top of the address space
        ctrl_addr = 32'hFFFF_FFFE; ctrl_addr_valid = 1'b1; ctrl_rd_wr = 1'b1; wrap_length = 16'd0;
        step(); ctrl_addr_valid = 1'b0;
        check("top req",  32'(bus_req), 32'd1);
        check("top we",   32'(bus_we), 32'd0);
        check("top addr", bus_addr, 32'hFFFF_FFFC);
        step();
        check("top resp req", 32'(bus_req), 32'd0);
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_0000;
        step(); bus_rvalid = 1'b0;
        check("top tx_valid", 32'(ctrl_data_tx_valid), 32'd1);
        check("top tx",       ctrl_data_tx, 32'hCAFE_0000);
        check("top wrap req", 32'(bus_req), 32'd1);
        check("top wrap addr", bus_addr, 32'h0);
        step(); bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_0001;
        step(); bus_rvalid = 1'b0;
        check("full req", 32'(bus_req), 32'd0);
        check("full tx",  ctrl_data_tx, 32'hCAFE_0000);
        bus_gnt = 1'b0; ctrl_data_tx_ready = 1'b1;
        step();
        check("pop1 tx",   ctrl_data_tx, 32'hCAFE_0001);
        check("pop1 req",  32'(bus_req), 32'd1);
        check("pop1 addr", bus_addr, 32'h4);
        step(); ctrl_data_tx_ready = 1'b0;
        check("pop2 tx_valid", 32'(ctrl_data_tx_valid), 32'd0);

        // Wrapped read, consumer stalled
        ctrl_addr = 32'h200; ctrl_addr_valid = 1'b1; ctrl_rd_wr = 1'b1; wrap_length = 16'd2;
        step(); ctrl_addr_valid = 1'b0;
        check("wrap addr0", bus_addr, 32'h200);
        check("wrap req0",  32'(bus_req), 32'd1);
        bus_gnt = 1'b1;
        step(); bus_rvalid = 1'b1; bus_rdata = 32'h5000_0000;
        step(); bus_rvalid = 1'b0;
        check("wrap addr1", bus_addr, 32'h204);
        check("wrap req1",  32'(bus_req), 32'd1);
        check("wrap first tx", ctrl_data_tx, 32'h5000_0000);
        step(); bus_rvalid = 1'b1; bus_rdata = 32'h5000_0001;
        step(); bus_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wrap full req", 32'(bus_req), 32'd0);
            step();
        end
        check("wrap head", ctrl_data_tx, 32'h5000_0000);
        ctrl_data_tx_ready = 1'b1;
        step(); ctrl_data_tx_ready = 1'b0;
        check("wrap again req",  32'(bus_req), 32'd1);
        check("wrap again addr", bus_addr, 32'h200);
        check("wrap second tx",  ctrl_data_tx, 32'h5000_0001);

        // New write transfer while a read response is pending
        step();
        ctrl_addr = 32'h400; ctrl_addr_valid = 1'b1; ctrl_rd_wr = 1'b0; wrap_length = 16'd0; bus_gnt = 1'b0;
        step(); ctrl_addr_valid = 1'b0;
        check("abort tx_valid", 32'(ctrl_data_tx_valid), 32'd0);
        check("abort req",      32'(bus_req), 32'd0);
        check("abort rx_ready", 32'(ctrl_data_rx_ready), 32'd0);
        bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        step(); bus_rvalid = 1'b0;
        check("drop tx_valid", 32'(ctrl_data_tx_valid), 32'd0);
        check("drop rx_ready", 32'(ctrl_data_rx_ready), 32'd1);
        ctrl_data_rx_valid = 1'b1; ctrl_data_rx = 32'h4444_0400;
        step(); ctrl_data_rx_valid = 1'b0;
        check("w400 req",   32'(bus_req), 32'd1);
        check("w400 we",    32'(bus_we), 32'd1);
        check("w400 addr",  bus_addr, 32'h400);
        check("w400 wdata", bus_wdata, 32'h4444_0400);
        bus_gnt = 1'b1;

        // Reset during RD_RESP with one word buffered
        step();
        ctrl_addr = 32'h500; ctrl_addr_valid = 1'b1; ctrl_rd_wr = 1'b1;
        step(); ctrl_addr_valid = 1'b0;
        step(); bus_rvalid = 1'b1; bus_rdata = 32'h7777_0500;
        step(); bus_rvalid = 1'b0;
        step();
        check("pre-rst tx_valid", 32'(ctrl_data_tx_valid), 32'd1);
        check("pre-rst tx",       ctrl_data_tx, 32'h7777_0500);
        sys_rstn = 1'b0;
        step();
        check_reset_outputs("midrst");
        sys_rstn = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h9999_9999;
        step(); bus_rvalid = 1'b0;
        check("trail tx_valid", 32'(ctrl_data_tx_valid), 32'd0);
        check("trail req",      32'(bus_req), 32'd0);
        check("trail rx_ready", 32'(ctrl_data_rx_ready), 32'd0);
        step();
        check("trail tx", ctrl_data_tx, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_bus_sequencer.md
SPI_SLAVE_BUS_SEQUENCER -- requirements
Module: spi_slave_bus_sequencer

Interface
REQ-001 Parameter PREFETCH_DEPTH, default 2, read-prefetch buffer depth in 32-bit words (legal 1..4).
REQ-002 sclk  input  1  clock; all state updates on rising edge.
REQ-003 sys_rstn  input  1  reset; synchronous, active-low, sampled on rising sclk.
REQ-004 ctrl_addr  input  32  transfer base byte address.
REQ-005 ctrl_addr_valid  input  1  one-cycle strobe; starts a new transfer.
REQ-006 ctrl_rd_wr  input  1  direction at the ctrl_addr_valid cycle: 1 = read, 0 = write.
REQ-007 ctrl_data_rx  input  32  write data word.
REQ-008 ctrl_data_rx_valid  input  1  write data word present.
REQ-009 ctrl_data_rx_ready  output  1  sequencer accepts write word this cycle.
REQ-010 ctrl_data_tx  output  32  read data word, prefetch buffer head.
REQ-011 ctrl_data_tx_valid  output  1  prefetch buffer non-empty.
REQ-012 ctrl_data_tx_ready  input  1  consumer pops head this cycle.
REQ-013 wrap_length  input  16  burst wrap length in words; 0 = linear, no wrap.
REQ-014 bus_req  output  1  bus request; held until granted.
REQ-015 bus_we  output  1  1 = write, 0 = read; stable while bus_req high.
REQ-016 bus_addr  output  32  word-aligned byte address; stable while bus_req high.
REQ-017 bus_wdata  output  32  write data; stable while bus_req high.
REQ-018 bus_gnt  input  1  request accepted; bus_req&bus_gnt = handshake.
REQ-019 bus_rvalid  input  1  read response strobe, >=1 cycle after read grant.
REQ-020 bus_rdata  input  32  read response data, valid with bus_rvalid.

Function
REQ-021 FSM states IDLE, WR_WAIT, WR_REQ, RD_REQ, RD_RESP; at most one bus transaction outstanding.
REQ-022 ctrl_addr_valid in any state: base <= {ctrl_addr[31:2],2'b00}, offset <= 0, prefetch buffer flushed; next state WR_WAIT if ctrl_rd_wr=0, RD_REQ if 1; from RD_RESP, in-flight read marked discard.
REQ-023 bus_addr = base + 4*offset, modulo 2^32 (address wraps past 0xFFFF_FFFC to 0).
REQ-024 Offset advance after each completed word: if wrap_length != 0 and offset+1 == wrap_length, offset <= 0; else offset <= offset+1 (16-bit).
REQ-025 WR_WAIT: ctrl_data_rx_ready = 1; on ctrl_data_rx_valid latch bus_wdata, go WR_REQ; ctrl_data_rx_ready = 0 in all other states.
REQ-026 WR_REQ: bus_req=1, bus_we=1; on bus_gnt advance offset, go WR_WAIT; write completes at grant, no response expected.
REQ-027 RD_REQ: bus_req=1, bus_we=0 only when buffer occupancy < PREFETCH_DEPTH; else bus_req=0, wait; on bus_gnt go RD_RESP.
REQ-028 RD_RESP: on bus_rvalid push bus_rdata unless discard set, advance offset, go RD_REQ; discarded response clears discard and returns to state selected by REQ-022.
REQ-029 Read with space reserved: buffer push can never overflow; push and pop in same cycle keeps occupancy unchanged.
REQ-030 Pop on ctrl_data_tx_valid & ctrl_data_tx_ready; ctrl_data_tx_ready while empty has no effect.
REQ-031 ctrl_data_tx_valid and ctrl_data_tx are registered buffer outputs; first read word visible earliest 1 cycle after bus_rvalid.
REQ-032 ctrl_addr_valid simultaneous with bus_gnt: granted transaction completes on bus (write stands, read discarded), new transfer starts per REQ-022.
REQ-033 ctrl_addr_valid simultaneous with pop or push: flush wins, occupancy 0 next cycle.
REQ-034 bus_req never deasserts or changes bus_we/bus_addr/bus_wdata before bus_gnt, except abort by ctrl_addr_valid while not granted.

Reset
REQ-035 sys_rstn=0 at rising edge: state IDLE, base 0, offset 0, buffer empty, discard 0.
REQ-036 Outputs during/after reset: bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, ctrl_data_rx_ready 0, ctrl_data_tx_valid 0, ctrl_data_tx 0.
REQ-037 Reset mid-transaction drops any in-flight read; later bus_rvalid in IDLE ignored.

Verification
REQ-038 Write addr 0x100, 3 words, bus_gnt immediate -> writes at 0x100, 0x104, 0x108 with matching data, one per handshake.
REQ-039 Read addr 0x200, wrap_length 2, consumer stalled -> exactly 2 reads (0x200, 0x204), bus_req low until pop; next read 0x200.
REQ-040 Read 0xFFFF_FFFC, wrap_length 0 -> reads 0xFFFF_FFFC then 0x0000_0000.
REQ-041 New ctrl_addr_valid (write, 0x400) while read in RD_RESP -> old rdata not pushed, tx_valid 0, next bus op write to 0x400.
REQ-042 bus_gnt held low 5 cycles on write -> bus_req, bus_addr, bus_wdata stable all 5 cycles, ctrl_data_rx_ready 0.
REQ-043 sys_rstn low during RD_RESP with 1 word buffered -> next cycle all outputs per REQ-036; trailing bus_rvalid ignored.
